gray_rx_decoder: RTL

Receive-side companion to the team's 3-bit up/down Gray-code counter FSM. The block samples a Gray-coded position bus and converts it to binary. It classifies each sampled change as an up step, a down step or an illegal jump, and keeps a signed position accumulator with wrap detection. It sits downstream of any Gray counter or encoder in the lab design and feeds displays or the next FSM stage.

---
 rtl/gray_rx_decoder_pkg.sv | 21 ++
 rtl/gray_rx_decoder_gray2bin.sv | 14 +
 rtl/gray_rx_decoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/gray_rx_decoder_pkg.sv
// Shared definitions for the Gray-code receive decoder: default widths,
// FSM state encodings and the step classification produced per sample.
package gray_rx_decoder_pkg;

  localparam int unsigned GRAY_W_DEF = 3;
  localparam int unsigned POS_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_ACQ   = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DELTA_NONE = 2'd0,
    DELTA_UP   = 2'd1,
    DELTA_DOWN = 2'd2,
    DELTA_JUMP = 2'd3
  } delta_e;

endpackage : gray_rx_decoder_pkg

// File: rtl/gray_rx_decoder_gray2bin.sv
// Purely combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray2bin #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule : gray2bin

// File: rtl/gray_rx_decoder.sv
// Gray-code position receiver: converts the sampled code to binary, classifies
// each change as up/down/jump and tracks a signed position with wrap pulses.
module gray_rx_decoder
  import gray_rx_decoder_pkg::*;
#(
  parameter int unsigned W     = GRAY_W_DEF,
  parameter int unsigned POS_W = POS_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [W-1:0]     gray_in,
  input  logic             clr_pos,
  output logic [W-1:0]     bin_out,
  output logic [POS_W-1:0] pos,
  output logic             dir_up,
  output logic             step,
  output logic             err,
  output logic             wrap,
  output logic             locked
);

  localparam logic [W-1:0]     CODE_ONE = W'(1);
  localparam logic [W-1:0]     CODE_MAX = '1;
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  state_e             state_q;
  logic [W-1:0]       bin_out_q;
  logic [POS_W-1:0]   pos_q;
  logic               dir_up_q;
  logic               step_q;
  logic               err_q;
  logic               wrap_q;
  logic               locked_q;

  logic [W-1:0]       cur_bin;
  logic [W-1:0]       code_diff;
  delta_e             delta_d;
  logic               wrap_d;
  logic [POS_W-1:0]   pos_up_d;
  logic [POS_W-1:0]   pos_dn_d;

  gray2bin #(
    .W (W)
  ) u_gray2bin (
    .gray_i (gray_in),
    .bin_o  (cur_bin)
  );

  assign code_diff = cur_bin - bin_out_q;
  assign pos_up_d  = pos_q + POS_ONE;
  assign pos_dn_d  = pos_q - POS_ONE;

  // Modular difference against the last accepted code decides the step type;
  // a wrap is an up step leaving the top code or a down step leaving zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    delta_d = DELTA_JUMP;
    wrap_d  = 1'b0;
    if (code_diff == '0) begin
      delta_d = DELTA_NONE;
    end else if (code_diff == CODE_ONE) begin
      delta_d = DELTA_UP;
      wrap_d  = (bin_out_q == CODE_MAX);
    end else if (code_diff == CODE_MAX) begin
      delta_d = DELTA_DOWN;
      wrap_d  = (bin_out_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= ST_ACQ;
      bin_out_q <= '0;
      pos_q     <= '0;
      dir_up_q  <= 1'b0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;

      if (sample_en) begin
        bin_out_q <= cur_bin;
        unique case (state_q)
          ST_ACQ: begin
            state_q  <= ST_TRACK;
            locked_q <= 1'b1;
          end

          ST_TRACK: begin
            unique case (delta_d)
              DELTA_UP: begin
                pos_q    <= pos_up_d;
                dir_up_q <= 1'b1;
                step_q   <= 1'b1;
                wrap_q   <= wrap_d;
              end
              DELTA_DOWN: begin
                pos_q    <= pos_dn_d;
                dir_up_q <= 1'b0;
                step_q   <= 1'b1;
                wrap_q   <= wrap_d;
              end
              DELTA_JUMP: begin
                err_q    <= 1'b1;
                state_q  <= ST_FAULT;
                locked_q <= 1'b0;
              end
              default: ;
            endcase
          end

          ST_FAULT: begin
            // A clean step only re-locks; the position is not trusted yet.
            unique case (delta_d)
              DELTA_UP, DELTA_DOWN: begin
                dir_up_q <= (delta_d == DELTA_UP);
                state_q  <= ST_TRACK;
                locked_q <= 1'b1;
              end
              DELTA_JUMP: begin
                err_q <= 1'b1;
              end
              default: ;
            endcase
          end

          default: begin
            state_q  <= ST_ACQ;
            locked_q <= 1'b0;
          end
        endcase
      end

      // Clearing wins over a same-cycle step; the step pulses still report it.
      if (clr_pos) begin
        pos_q <= '0;
      end
    end
  end

  assign bin_out = bin_out_q;
  assign pos     = pos_q;
  assign dir_up  = dir_up_q;
  assign step    = step_q;
  assign err     = err_q;
  assign wrap    = wrap_q;
  assign locked  = locked_q;

endmodule : gray_rx_decoder
